// File: rtl/rsa_key_streamer.sv
// -----------------------------------------------------------------------------
// rsa_key_streamer
//
// Transmit side of the RSA key-bundle stream. On start_i the block reads WORDS
// consecutive 32-bit words (exp_enc, mod_enc, wrapped AES key) from a
// synchronous word memory, starting at base_addr_i and wrapping modulo
// 2**ADDR_W. It forwards them in address order over a 32-bit valid/ready link
// to the RSA decryptor. A 2-entry output FIFO decouples memory latency from
// receiver back-pressure, so the link carries one word per cycle when
// tx_ready_i is held high.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   start_i        begin a transfer (honoured only in IDLE, ignored with abort_i)
//   base_addr_i    word address of bundle word 0, sampled with start_i
//   abort_i        cancel the current transfer; highest priority after rst
//   mem_rd_o       memory read strobe
//   mem_addr_o     memory read address, valid while mem_rd_o=1
//   mem_data_i     read data, valid exactly one cycle after mem_rd_o
//   tx_data_o      stream data (FIFO head)
//   tx_valid_o     stream valid (FIFO not empty)
//   tx_ready_i     stream ready; a beat is tx_valid_o & tx_ready_i
//   busy_o         high while fetching or draining
//   done_o         one-cycle pulse in the cycle after the final beat
//   checksum_o     XOR of all beats of the current or most recent transfer
// -----------------------------------------------------------------------------

// Property checker for the streamer's internal invariants. It has no outputs
// and adds no logic to the datapath.
module rsa_key_streamer_chk (
  input logic        clk,
  input logic        rst,
  input logic [1:0]  occ_i,
  input logic        inflight_i,
  input logic        fetch_i,
  input logic        mem_rd_i,
  input logic        abort_i,
  input logic        tx_valid_i,
  input logic        tx_ready_i,
  input logic [31:0] tx_data_i,
  input logic        busy_i,
  input logic        done_i
);

  // FIFO entries plus the outstanding read never exceed the FIFO depth.
  a_owed_le_depth: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ_i} + {2'b00, inflight_i}) <= 3'd2);

  // A presented word is held, unchanged, until it is accepted.
  a_tx_hold: assert property (@(posedge clk) disable iff (rst)
    (tx_valid_i && !tx_ready_i && !abort_i) |=> (tx_valid_i && $stable(tx_data_i)));

  // Reads are only issued while fetching.
  a_rd_in_fetch: assert property (@(posedge clk) disable iff (rst)
    mem_rd_i |-> fetch_i);

  // The completion pulse arrives after the block has returned to IDLE.
  a_done_idle: assert property (@(posedge clk) disable iff (rst)
    done_i |-> !busy_i);

endmodule

module rsa_key_streamer #(
  parameter int ADDR_W = 12,
  parameter int WORDS  = 268
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              abort_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       checksum_o
);

  localparam int               CNT_W    = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;          // next read address
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;      // reads issued this transfer
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;  // beats accepted this transfer
  logic              inflight_q, inflight_d;  // a read returns data this cycle
  logic [31:0]       ent0_q, ent0_d;          // FIFO entry 0
  logic [31:0]       ent1_q, ent1_d;          // FIFO entry 1
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;            // FIFO occupancy 0..2
  logic [31:0]       checksum_q, checksum_d;
  logic              done_q, done_d;

  logic              beat_s;
  logic              push_s;
  logic              rd_s;
  logic              last_beat_s;
  logic              start_ok_s;
  logic [2:0]        owed_s;
  logic [2:0]        limit_s;
  logic [31:0]       head_s;

  // Stream handshake and read-issue decisions.
  always_comb begin
    head_s      = rd_ptr_q ? ent1_q : ent0_q;
    beat_s      = (occ_q != 2'd0) && tx_ready_i;
    // Data from last cycle's read lands in the FIFO at the end of this cycle.
    push_s      = inflight_q;
    // Words already owed to the FIFO: stored ones plus the one on its way.
    owed_s      = {1'b0, occ_q} + {2'b00, inflight_q};
    // A beat this cycle frees a slot, so one more read is allowed.
    limit_s     = 3'd2 + {2'b00, beat_s};
    rd_s        = (state_q == S_FETCH) && (owed_s < limit_s);
    last_beat_s = beat_s && (beat_cnt_q == LAST_IDX);
    start_ok_s  = (state_q == S_IDLE) && start_i && !abort_i;
  end

  // Next-state logic for the controller, FIFO, counters and checksum.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    inflight_d = 1'b0;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    checksum_d = checksum_q;
    done_d     = 1'b0;

    if (abort_i) begin
      // Flush everything; the read returning next cycle is dropped because
      // inflight is cleared. Checksum keeps its partial value.
      state_d    = S_IDLE;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      occ_d      = 2'd0;
      inflight_d = 1'b0;
    end else begin
      // Read address generation; wraps silently at 2**ADDR_W.
      if (rd_s) begin
        addr_d   = addr_q + ADDR_W'(1);
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end else begin
        addr_d   = addr_q;
        rd_cnt_d = rd_cnt_q;
      end
      inflight_d = rd_s;

      if (push_s) begin
        if (wr_ptr_q) begin
          ent1_d = mem_data_i;
        end else begin
          ent0_d = mem_data_i;
        end
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (beat_s) begin
        rd_ptr_d   = ~rd_ptr_q;
        checksum_d = checksum_q ^ head_s;
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end else begin
        rd_ptr_d   = rd_ptr_q;
        checksum_d = checksum_q;
        beat_cnt_d = beat_cnt_q;
      end

      occ_d  = occ_q + {1'b0, push_s} - {1'b0, beat_s};
      done_d = last_beat_s;

      case (state_q)
        S_IDLE: begin
          if (start_ok_s) begin
            state_d    = S_FETCH;
            addr_d     = base_addr_i;
            rd_cnt_d   = {CNT_W{1'b0}};
            beat_cnt_d = {CNT_W{1'b0}};
            checksum_d = 32'h0000_0000;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            occ_d      = 2'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          // The read issued this cycle is the bundle's last one.
          if (rd_s && (rd_cnt_q == LAST_IDX)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (last_beat_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      rd_cnt_q   <= {CNT_W{1'b0}};
      beat_cnt_q <= {CNT_W{1'b0}};
      inflight_q <= 1'b0;
      ent0_q     <= 32'h0000_0000;
      ent1_q     <= 32'h0000_0000;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      checksum_q <= 32'h0000_0000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      checksum_q <= checksum_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd_o   = rd_s;
  assign mem_addr_o = addr_q;
  assign tx_data_o  = head_s;
  assign tx_valid_o = (occ_q != 2'd0);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign checksum_o = checksum_q;

  rsa_key_streamer_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .occ_i      (occ_q),
    .inflight_i (inflight_q),
    .fetch_i    (state_q == S_FETCH),
    .mem_rd_i   (rd_s),
    .abort_i    (abort_i),
    .tx_valid_i (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_data_i  (tx_data_o),
    .busy_i     (busy_o),
    .done_i     (done_o)
  );

endmodule

// File: tb/tb_rsa_key_streamer.sv
// -----------------------------------------------------------------------------
// tb_rsa_key_streamer
//
// Scoreboard bench: starting a transfer pushes the expected word sequence into
// a queue; a negedge monitor pops and compares on every beat, checks done_o
// timing, stall stability, read addresses and FIFO debt. The main process
// runs directed scenarios and checks hand-computed end results.
// -----------------------------------------------------------------------------
module tb_rsa_key_streamer;

  localparam int ADDR_W = 12;
  localparam int WORDS  = 268;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              abort_i;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_i;
  logic [31:0]       tx_data_o;
  logic              tx_valid_o;
  logic              tx_ready_i;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       checksum_o;

  rsa_key_streamer #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .abort_i     (abort_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .checksum_o  (checksum_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 | {20'h00000, a};
  endfunction

  // Synchronous memory; data is garbage except the cycle after a read.
  always @(posedge clk) mem_data_i <= mem_rd_o ? mem_word(mem_addr_o) : 32'hDEAD_BEEF;

  // Scoreboard state
  logic [31:0]       exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  int                beats_seen = 0;
  int                done_seen = 0;
  int                start_cyc = 0;
  int                first_beat_cyc = -1;
  int                last_beat_cyc = -1;
  int                done_cyc = -1;
  bit                pending_done = 1'b0;
  logic [31:0]       sb_xor = 32'h0;
  logic [ADDR_W-1:0] exp_addr = '0;
  int                reads_seen = 0;
  int                addr_err = 0;
  int                owed = 0;
  int                max_owed = 0;
  bit                prev_hold = 1'b0;
  logic [31:0]       prev_data = 32'h0;
  bit                ready_mode = 1'b0;
  int                phase = 0;

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (prev_hold) begin
        n_tests++;
        if (!tx_valid_o || tx_data_o !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h",
                   tx_valid_o, tx_data_o, prev_data);
        end
      end
      if (mem_rd_o) begin
        if (mem_addr_o !== exp_addr) addr_err++;
        exp_addr   = exp_addr + 12'd1;
        reads_seen++;
      end
      if (tx_valid_o && tx_ready_i && !abort_i) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra: got %h, required no beat", tx_data_o);
        end else begin
          e = exp_q.pop_front();
          if (tx_data_o !== e) begin
            n_fail++;
            $display("FAIL beat_data[%0d]: got %h required %h", beats_seen, tx_data_o, e);
          end
          sb_xor = sb_xor ^ e;
          if (beats_seen == 0) first_beat_cyc = cyc - start_cyc;
          last_beat_cyc = cyc - start_cyc;
          if (exp_q.size() == 0) pending_done = 1'b1;
        end
        beats_seen++;
      end
      if (done_o) begin
        n_tests++;
        done_seen++;
        done_cyc = cyc - start_cyc;
        if (!pending_done || done_cyc != last_beat_cyc + 1) begin
          n_fail++;
          $display("FAIL done_timing: done at cycle %0d, required cycle %0d (pending=%0b)",
                   done_cyc, last_beat_cyc + 1, pending_done);
        end
        pending_done = 1'b0;
      end
      if (abort_i) owed = 0;
      else owed = owed + (mem_rd_o ? 1 : 0) - ((tx_valid_o && tx_ready_i) ? 1 : 0);
      if (owed > max_owed) max_owed = owed;
      prev_hold = tx_valid_o && !tx_ready_i && !abort_i;
      prev_data = tx_data_o;
    end else begin
      prev_hold = 1'b0;
      owed      = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ready();
    tx_ready_i = ready_mode ? ((phase % 3) == 0) : 1'b1;
    phase++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},   32'(mem_rd_o),   32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'd0);
    check({tag, "_busy"},     32'(busy_o),     32'd0);
    check({tag, "_done"},     32'(done_o),     32'd0);
    check({tag, "_tx_data"},  tx_data_o,       32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_checksum"}, checksum_o,      32'd0);
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    exp_q.delete();
    for (int n = 0; n < WORDS; n++) begin
      a = base + n[ADDR_W-1:0];
      exp_q.push_back(mem_word(a));
    end
    exp_addr     = base;
    sb_xor       = 32'h0;
    beats_seen   = 0;
    done_seen    = 0;
    reads_seen   = 0;
    addr_err     = 0;
    max_owed     = 0;
    pending_done = 1'b0;
    first_beat_cyc = -1;
    start_cyc    = cyc;
    base_addr_i  = base;
    start_i      = 1'b1;
    drive_ready();
    tick();
    start_i      = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (beats_seen >= target) begin
        hit = 1'b1;
        break;
      end
      drive_ready();
      tick();
    end
    if (!hit && beats_seen >= target) hit = 1'b1;
    if (!hit) check("wait_beats_timeout", 32'(beats_seen), 32'(target));
  endtask

  task automatic wait_done(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_seen >= 1) begin
        hit = 1'b1;
        break;
      end
      drive_ready();
      tick();
    end
    if (!hit && done_seen >= 1) hit = 1'b1;
    if (!hit) check("wait_done_timeout", 32'(done_seen), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tx_ready_i = 1'b1;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; tx_ready_i = 1'b0; base_addr_i = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // 1: base 0, ready held high, exact cycle timing.
    ready_mode = 1'b0;
    start_xfer(12'h000);
    wait_done(400);
    check("t1_beats",      32'(beats_seen),     32'd268);
    check("t1_first_beat", 32'(first_beat_cyc), 32'd3);
    check("t1_last_beat",  32'(last_beat_cyc),  32'd270);
    check("t1_done_cyc",   32'(done_cyc),       32'd271);
    check("t1_checksum",   checksum_o,          32'h0000_0000);
    check("t1_reads",      32'(reads_seen),     32'd268);
    check("t1_addr_err",   32'(addr_err),       32'd0);
    idle_cycles(5);
    check("t1_done_once",  32'(done_seen),      32'd1);
    check("t1_idle_busy",  32'(busy_o),         32'd0);
    check("t1_cks_held",   checksum_o,          sb_xor);

    // 2: ready pattern 1,0,0; base 5.
    ready_mode = 1'b1;
    phase      = 0;
    start_xfer(12'h005);
    wait_done(1200);
    ready_mode = 1'b0;
    check("t2_beats",      32'(beats_seen),     32'd268);
    check("t2_checksum",   checksum_o,          32'h0000_0114);
    check("t2_owed_le_2",  32'(max_owed <= 2),  32'd1);
    check("t2_addr_err",   32'(addr_err),       32'd0);
    check("t2_queue_empty", 32'(exp_q.size()),  32'd0);

    // 3: address wrap from FF0.
    start_xfer(12'hFF0);
    wait_done(400);
    check("t3_beats",      32'(beats_seen),     32'd268);
    check("t3_reads",      32'(reads_seen),     32'd268);
    check("t3_addr_err",   32'(addr_err),       32'd0);
    check("t3_checksum",   checksum_o,          32'h0000_0000);

    // 4: abort after beat 100, then a clean restart.
    start_xfer(12'h000);
    wait_beats(101, 400);
    abort_i    = 1'b1;
    tx_ready_i = 1'b0;
    tick();
    abort_i    = 1'b0;
    exp_q.delete();
    pending_done = 1'b0;
    check("t4_valid_off",  32'(tx_valid_o),     32'd0);
    check("t4_rd_off",     32'(mem_rd_o),       32'd0);
    check("t4_busy_off",   32'(busy_o),         32'd0);
    check("t4_partial",    checksum_o,          32'hA500_0064);
    idle_cycles(8);
    check("t4_no_done",    32'(done_seen),      32'd0);
    check("t4_still_idle", 32'(tx_valid_o),     32'd0);
    start_xfer(12'h000);
    check("t4_cks_clear",  checksum_o,          32'h0000_0000);
    wait_done(400);
    check("t4_beats",      32'(beats_seen),     32'd268);
    check("t4_checksum",   checksum_o,          32'h0000_0000);

    // 5: start during a transfer is ignored; start+abort in IDLE stays idle.
    start_xfer(12'h000);
    wait_beats(50, 200);
    start_i     = 1'b1;
    base_addr_i = 12'h123;
    drive_ready();
    tick();
    start_i     = 1'b0;
    base_addr_i = 12'h000;
    wait_done(400);
    check("t5_beats",      32'(beats_seen),     32'd268);
    check("t5_checksum",   checksum_o,          32'h0000_0000);
    check("t5_addr_err",   32'(addr_err),       32'd0);
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("t5_sa_busy",    32'(busy_o),         32'd0);
    tick();
    check("t5_sa_busy2",   32'(busy_o),         32'd0);
    check("t5_sa_rd",      32'(mem_rd_o),       32'd0);

    // 6: reset at beat 200, then a clean transfer.
    start_xfer(12'h000);
    wait_beats(200, 400);
    rst        = 1'b1;
    tx_ready_i = 1'b0;
    tick();
    check_all_zero("t6_rst");
    rst = 1'b0;
    exp_q.delete();
    pending_done = 1'b0;
    idle_cycles(4);
    check("t6_no_done",    32'(done_seen),      32'd0);
    start_xfer(12'h010);
    wait_done(400);
    check("t6_beats",      32'(beats_seen),     32'd268);
    check("t6_checksum",   checksum_o,          sb_xor);
    check("t6_addr_err",   32'(addr_err),       32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
